// File: rtl/fm_ram_pkg.sv
// Shared types and constants for the ping-pong feature-map RAM.
// FM_RAM_DROP_CNT_EN: when defined, the top exposes a saturating drop counter.
package fm_ram_pkg;

  localparam int RD_LAT_MAX = 4;

  // Bank index: two banks, one bit
  typedef logic bank_t;

  // Events that set err_drop; each is one bit of the drop vector
  typedef enum logic [1:0] {
    DROP_WR      = 2'd0,  // write strobe refused (bank full or address out of range)
    DROP_RD      = 2'd1,  // read strobe refused (bank not ready or address out of range)
    DROP_WR_DONE = 2'd2,  // wr_done while the write bank is not free
    DROP_RD_DONE = 2'd3   // rd_done while the read bank holds no frame
  } drop_evt_e;

  localparam int DROP_EVT_N = 4;

  // Number of drop events raised in one cycle
  function automatic logic [2:0] drop_count(input logic [DROP_EVT_N-1:0] evt);
    logic [2:0] cnt;
    cnt = '0;
    for (int i = 0; i < DROP_EVT_N; i++) cnt = cnt + 3'(evt[i]);
    return cnt;
  endfunction

endpackage

// File: rtl/conv_fm_pingpong_ram_if.sv
// Producer/consumer bus of the ping-pong feature-map RAM.
// master = producer/consumer side, slave = the RAM.
// FM_RAM_DROP_CNT_EN: when defined, adds drop_cnt.
interface conv_fm_pingpong_ram_if
  import fm_ram_pkg::*;
#(
  parameter int DATA_W = 64,
  parameter int ADDR_W = 12
);
  // Write side
  logic              wr_en;
  logic [ADDR_W-1:0] wr_addr;
  logic [DATA_W-1:0] wr_data;
  logic              wr_done;
  logic              wr_rdy;
  bank_t             wr_bank;
  // Read side
  logic              rd_en;
  logic [ADDR_W-1:0] rd_addr;
  logic              rd_done;
  logic              rd_rdy;
  bank_t             rd_bank;
  logic [DATA_W-1:0] rd_data;
  logic              rd_valid;
  // Status
  logic              err_drop;
`ifdef FM_RAM_DROP_CNT_EN
  logic [15:0]       drop_cnt;
`endif

  modport master (
    output wr_en, wr_addr, wr_data, wr_done, rd_en, rd_addr, rd_done,
    input  wr_rdy, wr_bank, rd_rdy, rd_bank, rd_data, rd_valid, err_drop
`ifdef FM_RAM_DROP_CNT_EN
    , input drop_cnt
`endif
  );

  modport slave (
    input  wr_en, wr_addr, wr_data, wr_done, rd_en, rd_addr, rd_done,
    output wr_rdy, wr_bank, rd_rdy, rd_bank, rd_data, rd_valid, err_drop
`ifdef FM_RAM_DROP_CNT_EN
    , output drop_cnt
`endif
  );

endinterface

// File: rtl/fm_sdp_ram.sv
// One bank: inferred simple dual-port RAM with a registered read pipeline.
// Each pipeline stage loads only when the top enables it, so the last
// stage holds its value between reads.
module fm_sdp_ram
  import fm_ram_pkg::*;
#(
  parameter int DATA_W = 64,
  parameter int ADDR_W = 12,
  parameter int DEPTH  = 2496,
  parameter int RD_LAT = 2
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              i_we,
  input  logic [ADDR_W-1:0] i_wr_addr,
  input  logic [DATA_W-1:0] i_wr_data,
  input  logic [RD_LAT-1:0] i_stage_en,
  input  logic [ADDR_W-1:0] i_rd_addr,
  output logic [DATA_W-1:0] o_rd_data
);

  logic [DATA_W-1:0] r_mem  [0:DEPTH-1];
  logic [DATA_W-1:0] r_data [RD_LAT];

  // Memory write port
  // NOTE: the array has no reset so it maps onto block RAM; only the read pipeline is reset.
  always_ff @(posedge clk) begin
    if (i_we) r_mem[i_wr_addr] <= i_wr_data;
  end

  // Read pipeline: stage 0 samples the array, later stages shift when enabled
  // NOTE: non-blocking assignments make every stage sample the previous stage's old value.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int k = 0; k < RD_LAT; k++) r_data[k] <= '0;
    end else begin
      if (i_stage_en[0]) r_data[0] <= r_mem[i_rd_addr];
      for (int k = 1; k < RD_LAT; k++) begin
        if (i_stage_en[k]) r_data[k] <= r_data[k-1];
      end
    end
  end

  assign o_rd_data = r_data[RD_LAT-1];

endmodule

// File: rtl/conv_fm_pingpong_ram.sv
// Double-buffered feature-map RAM: the producer fills one bank while the
// consumer reads the other; wr_done/rd_done hand banks across.
// FM_RAM_DROP_CNT_EN: when defined, adds a 16-bit saturating drop counter.
module conv_fm_pingpong_ram
  import fm_ram_pkg::*;
#(
  parameter int DATA_W = 64,
  parameter int ADDR_W = 12,
  parameter int DEPTH  = 2496,
  parameter int RD_LAT = 2
) (
  input  logic                   clk,
  input  logic                   rst_n,
  conv_fm_pingpong_ram_if.slave  bus
);

  localparam logic [ADDR_W:0] DEPTH_C = (ADDR_W+1)'(DEPTH);

  logic [1:0]        r_full;
  bank_t             r_wbank;
  bank_t             r_rbank;
  logic              r_err_drop;
  logic [RD_LAT-1:0] r_vld;
  bank_t             r_sel [RD_LAT];

  logic              w_wr_rdy;
  logic              w_rd_rdy;
  logic              w_wr_in_rng;
  logic              w_rd_in_rng;
  logic              w_wr_acc;
  logic              w_rd_acc;
  logic              w_wr_done_acc;
  logic              w_rd_done_acc;
  logic [DROP_EVT_N-1:0] w_drop;
  logic [RD_LAT-1:0] w_stg_en    [2];
  logic [DATA_W-1:0] w_bank_data [2];

  assign w_wr_rdy      = ~r_full[r_wbank];
  assign w_rd_rdy      = r_full[r_rbank];
  assign w_wr_in_rng   = {1'b0, bus.wr_addr} < DEPTH_C;
  assign w_rd_in_rng   = {1'b0, bus.rd_addr} < DEPTH_C;
  assign w_wr_acc      = bus.wr_en & w_wr_rdy & w_wr_in_rng;
  assign w_rd_acc      = bus.rd_en & w_rd_rdy & w_rd_in_rng;
  assign w_wr_done_acc = bus.wr_done & w_wr_rdy;
  assign w_rd_done_acc = bus.rd_done & w_rd_rdy;

  // Classify refused strobes into drop events
  // NOTE: every always_comb output gets a default first so no latch is inferred.
  always_comb begin
    w_drop               = '0;
    w_drop[DROP_WR]      = bus.wr_en   & ~(w_wr_rdy & w_wr_in_rng);
    w_drop[DROP_RD]      = bus.rd_en   & ~(w_rd_rdy & w_rd_in_rng);
    w_drop[DROP_WR_DONE] = bus.wr_done & ~w_wr_rdy;
    w_drop[DROP_RD_DONE] = bus.rd_done & ~w_rd_rdy;
  end

  // Bank ownership: a done on each side flips its pointer and the owning full flag
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_full  <= '0;
      r_wbank <= 1'b0;
      r_rbank <= 1'b0;
    end else begin
      if (w_wr_done_acc) begin
        r_full[r_wbank] <= 1'b1;
        r_wbank         <= ~r_wbank;
      end
      if (w_rd_done_acc) begin
        r_full[r_rbank] <= 1'b0;
        r_rbank         <= ~r_rbank;
      end
    end
  end

  // Read valid shift register with the issuing bank carried alongside each read
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_vld <= '0;
      for (int k = 0; k < RD_LAT; k++) r_sel[k] <= 1'b0;
    end else begin
      r_vld[0] <= w_rd_acc;
      if (w_rd_acc) r_sel[0] <= r_rbank;
      for (int k = 1; k < RD_LAT; k++) begin
        r_vld[k] <= r_vld[k-1];
        if (r_vld[k-1]) r_sel[k] <= r_sel[k-1];
      end
    end
  end

  // Per-bank pipeline stage enables: a stage moves only for reads of its own bank
  always_comb begin
    for (int b = 0; b < 2; b++) begin
      w_stg_en[b]    = '0;
      w_stg_en[b][0] = w_rd_acc & (r_rbank == bank_t'(b));
      for (int k = 1; k < RD_LAT; k++) begin
        w_stg_en[b][k] = r_vld[k-1] & (r_sel[k-1] == bank_t'(b));
      end
    end
  end

  for (genvar b = 0; b < 2; b++) begin : g_bank
    fm_sdp_ram #(
      .DATA_W (DATA_W),
      .ADDR_W (ADDR_W),
      .DEPTH  (DEPTH),
      .RD_LAT (RD_LAT)
    ) u_ram (
      .clk        (clk),
      .rst_n      (rst_n),
      .i_we       (w_wr_acc & (r_wbank == bank_t'(b))),
      .i_wr_addr  (bus.wr_addr),
      .i_wr_data  (bus.wr_data),
      .i_stage_en (w_stg_en[b]),
      .i_rd_addr  (bus.rd_addr),
      .o_rd_data  (w_bank_data[b])
    );
  end

  // Sticky error flag
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_err_drop <= 1'b0;
    else        r_err_drop <= r_err_drop | (|w_drop);
  end

`ifdef FM_RAM_DROP_CNT_EN
  logic [15:0] r_drop_cnt;
  logic [16:0] w_cnt_sum;

  assign w_cnt_sum = {1'b0, r_drop_cnt} + 17'(drop_count(w_drop));

  // Saturating count of drop events (several may occur in one cycle)
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_drop_cnt <= '0;
    else        r_drop_cnt <= w_cnt_sum[16] ? 16'hFFFF : w_cnt_sum[15:0];
  end

  assign bus.drop_cnt = r_drop_cnt;
`endif

  assign bus.wr_rdy   = w_wr_rdy;
  assign bus.wr_bank  = r_wbank;
  assign bus.rd_rdy   = w_rd_rdy;
  assign bus.rd_bank  = r_rbank;
  assign bus.rd_data  = w_bank_data[r_sel[RD_LAT-1]];
  assign bus.rd_valid = r_vld[RD_LAT-1];
  assign bus.err_drop = r_err_drop;

endmodule
